// File: rtl/udma_lsu_tap_burst.sv
// UART-driven bus master: decodes read/write burst commands from a byte stream,
// runs req/gnt bus cycles, returns read data LSB first or a 0x06 ack after writes.
module udma_lsu_tap_burst #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_BYTES = 4,
    parameter int MAX_BURST  = 16,
    parameter int TO_CYCLES  = 65535
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    en_i,
    input  logic                    rx_valid_i,
    input  logic [7:0]              rx_data_i,
    input  logic                    tx_busy_i,
    output logic                    tx_valid_o,
    output logic [7:0]              tx_data_o,
    output logic                    req_o,
    output logic                    we_o,
    input  logic                    gnt_i,
    output logic [31:0]             addr_o,
    output logic [8*DATA_BYTES-1:0] data_o,
    input  logic                    valid_i,
    input  logic [8*DATA_BYTES-1:0] data_i,
    output logic                    busy_o,
    output logic                    err_o,
    input  logic                    err_clr_i
);
    localparam int DW   = 8 * DATA_BYTES;
    localparam int BC_W = 2;
    localparam int TO_W = $clog2(TO_CYCLES + 1);
    localparam logic [7:0]      CMD_WR    = 8'hA5;
    localparam logic [7:0]      CMD_RD    = 8'h5A;
    localparam logic [7:0]      ACK_BYTE  = 8'h06;
    localparam logic [8:0]      MAX_WORDS = 9'(MAX_BURST);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ADDR  = 4'd1,
        S_LEN   = 4'd2,
        S_WDATA = 4'd3,
        S_WREQ  = 4'd4,
        S_RREQ  = 4'd5,
        S_RWAIT = 4'd6,
        S_RSEND = 4'd7,
        S_ACK   = 4'd8
    } state_t;

    state_t            state_r, state_next_s;
    logic              we_r, req_r, tx_valid_r, err_r, busy_r;
    logic [31:0]       addr_r;
    logic [DW-1:0]     wdata_r, rdata_r;
    logic [7:0]        tx_data_r;
    logic [8:0]        words_left_r;
    logic [BC_W-1:0]   byte_cnt_r;
    logic [TO_W-1:0]   to_cnt_r;

    logic              cmd_hit_s, bus_done_s, tx_fire_s, timeout_s;
    logic              len_ok_s, last_addr_s, last_data_s;
    logic [8:0]        len_words_s;
    logic              req_next_s, tx_valid_next_s, err_set_s;
    logic [7:0]        tx_data_next_s, tx_byte_s;

    assign cmd_hit_s   = (rx_data_i == CMD_WR) || (rx_data_i == CMD_RD);
    assign bus_done_s  = req_r & gnt_i;
    assign tx_fire_s   = ~tx_valid_r & ~tx_busy_i;
    assign timeout_s   = (to_cnt_r == TO_LAST) & ~rx_valid_i;
    assign len_words_s = {1'b0, rx_data_i} + 9'd1;
    assign len_ok_s    = (len_words_s <= MAX_WORDS);
    assign last_addr_s = (byte_cnt_r == BC_W'(ADDR_BYTES - 1));
    assign last_data_s = (byte_cnt_r == BC_W'(DATA_BYTES - 1));

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; disable overrides everything and abandons any bus cycle
    always_comb begin
        state_next_s = state_r;
        if (!en_i) begin
            state_next_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (rx_valid_i && cmd_hit_s) state_next_s = S_ADDR;
                    else                         state_next_s = S_IDLE;
                end
                S_ADDR: begin
                    if (rx_valid_i)     state_next_s = last_addr_s ? S_LEN : S_ADDR;
                    else if (timeout_s) state_next_s = S_IDLE;
                    else                state_next_s = S_ADDR;
                end
                S_LEN: begin
                    if (rx_valid_i)     state_next_s = !len_ok_s ? S_IDLE : (we_r ? S_WDATA : S_RREQ);
                    else if (timeout_s) state_next_s = S_IDLE;
                    else                state_next_s = S_LEN;
                end
                S_WDATA: begin
                    if (rx_valid_i)     state_next_s = last_data_s ? S_WREQ : S_WDATA;
                    else if (timeout_s) state_next_s = S_IDLE;
                    else                state_next_s = S_WDATA;
                end
                S_WREQ: begin
                    if (bus_done_s) state_next_s = (words_left_r > 9'd1) ? S_WDATA : S_ACK;
                    else            state_next_s = S_WREQ;
                end
                S_RREQ: begin
                    if (bus_done_s) state_next_s = S_RWAIT;
                    else            state_next_s = S_RREQ;
                end
                S_RWAIT: begin
                    if (valid_i) state_next_s = S_RSEND;
                    else         state_next_s = S_RWAIT;
                end
                S_RSEND: begin
                    if (tx_fire_s && last_data_s) state_next_s = (words_left_r != 9'd0) ? S_RREQ : S_IDLE;
                    else                          state_next_s = S_RSEND;
                end
                S_ACK: begin
                    if (tx_fire_s) state_next_s = S_IDLE;
                    else           state_next_s = S_ACK;
                end
                default: state_next_s = S_IDLE;
            endcase
        end
    end

    // Output decode: next values of the registered handshake, tx and error outputs
    always_comb begin
        tx_byte_s = 8'h00;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (byte_cnt_r == BC_W'(i)) tx_byte_s = rdata_r[8*i +: 8];
            else                        tx_byte_s = tx_byte_s;
        end
        req_next_s      = 1'b0;
        tx_valid_next_s = 1'b0;
        tx_data_next_s  = tx_data_r;
        err_set_s       = 1'b0;
        if (en_i) begin
            case (state_r)
                S_ADDR, S_WDATA: err_set_s = timeout_s;
                S_LEN:           err_set_s = timeout_s | (rx_valid_i & ~len_ok_s);
                S_WREQ, S_RREQ: begin
                    req_next_s = ~bus_done_s;
                    err_set_s  = rx_valid_i;
                end
                S_RWAIT:         err_set_s = rx_valid_i;
                S_RSEND: begin
                    err_set_s       = rx_valid_i;
                    tx_valid_next_s = tx_fire_s;
                    if (tx_fire_s) tx_data_next_s = tx_byte_s;
                    else           tx_data_next_s = tx_data_r;
                end
                S_ACK: begin
                    err_set_s       = rx_valid_i;
                    tx_valid_next_s = tx_fire_s;
                    if (tx_fire_s) tx_data_next_s = ACK_BYTE;
                    else           tx_data_next_s = tx_data_r;
                end
                default:         err_set_s = 1'b0;
            endcase
        end else begin
            err_set_s = 1'b0;
        end
    end

    // Registered outputs; a new error event beats a simultaneous clear
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            req_r      <= 1'b0;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            req_r      <= req_next_s;
            tx_valid_r <= tx_valid_next_s;
            tx_data_r  <= tx_data_next_s;
            busy_r     <= (state_next_s != S_IDLE);
            if (err_set_s)      err_r <= 1'b1;
            else if (err_clr_i) err_r <= 1'b0;
            else                err_r <= err_r;
        end
    end

    // Command, address, data and counter datapath
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            we_r         <= 1'b0;
            addr_r       <= 32'h0000_0000;
            wdata_r      <= '0;
            rdata_r      <= '0;
            words_left_r <= 9'd0;
            byte_cnt_r   <= '0;
            to_cnt_r     <= '0;
        end else if (!en_i) begin
            byte_cnt_r <= '0;
            to_cnt_r   <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (rx_valid_i && cmd_hit_s) begin
                        we_r       <= (rx_data_i == CMD_WR);
                        addr_r     <= 32'h0000_0000;
                        byte_cnt_r <= '0;
                        to_cnt_r   <= '0;
                    end
                end
                S_ADDR: begin
                    if (rx_valid_i) begin
                        for (int i = 0; i < ADDR_BYTES; i++) begin
                            if (byte_cnt_r == BC_W'(i)) addr_r[8*i +: 8] <= rx_data_i;
                        end
                        byte_cnt_r <= last_addr_s ? '0 : byte_cnt_r + BC_W'(1);
                        to_cnt_r   <= '0;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                S_LEN: begin
                    if (rx_valid_i) begin
                        words_left_r <= len_words_s;
                        byte_cnt_r   <= '0;
                        to_cnt_r     <= '0;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                S_WDATA: begin
                    if (rx_valid_i) begin
                        for (int i = 0; i < DATA_BYTES; i++) begin
                            if (byte_cnt_r == BC_W'(i)) wdata_r[8*i +: 8] <= rx_data_i;
                        end
                        byte_cnt_r <= last_data_s ? '0 : byte_cnt_r + BC_W'(1);
                        to_cnt_r   <= '0;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                S_WREQ, S_RREQ: begin
                    if (bus_done_s) begin
                        addr_r       <= addr_r + 32'(DATA_BYTES);
                        words_left_r <= words_left_r - 9'd1;
                    end
                end
                S_RWAIT: begin
                    if (valid_i) begin
                        rdata_r    <= data_i;
                        byte_cnt_r <= '0;
                    end
                end
                S_RSEND: begin
                    if (tx_fire_s) byte_cnt_r <= last_data_s ? '0 : byte_cnt_r + BC_W'(1);
                end
                default: begin
                    to_cnt_r <= '0;
                end
            endcase
        end
    end

    assign tx_valid_o = tx_valid_r;
    assign tx_data_o  = tx_data_r;
    assign req_o      = req_r;
    assign we_o       = we_r;
    assign addr_o     = addr_r;
    assign data_o     = wdata_r;
    assign busy_o     = busy_r;
    assign err_o      = err_r;

endmodule

// File: tb/tb_udma_lsu_tap_burst.sv
// Directed bench for udma_lsu_tap_burst: write/read bursts, wrap, overlength,
// timeout, tx back-pressure, rx-while-busy, disable and async reset.
module tb_udma_lsu_tap_burst;
    localparam int TO = 20;

    logic        clk, rstn_i, en_i, rx_valid_i, tx_busy_i, tx_valid_o;
    logic        req_o, we_o, gnt_i, valid_i, busy_o, err_o, err_clr_i;
    logic [7:0]  rx_data_i, tx_data_o;
    logic [31:0] addr_o, data_o, data_i;

    int chk_total = 0;
    int chk_pass  = 0;

    logic [31:0] bus_addr_log [16];
    logic [31:0] bus_data_log [16];
    logic        bus_we_log   [16];
    int          bus_cnt = 0;
    logic [7:0]  tx_log [32];
    int          tx_cnt = 0;
    logic [31:0] rd_data [4];
    int          rd_idx = 0;
    logic        gnt_hold = 1'b0;
    int          req_cycles = 0, hs_viol = 0, consec_viol = 0, busy_viol = 0;

    udma_lsu_tap_burst #(
        .DATA_BYTES(4), .ADDR_BYTES(4), .MAX_BURST(16), .TO_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rstn_i(rstn_i), .en_i(en_i),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .tx_busy_i(tx_busy_i),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o),
        .req_o(req_o), .we_o(we_o), .gnt_i(gnt_i), .addr_o(addr_o), .data_o(data_o),
        .valid_i(valid_i), .data_i(data_i),
        .busy_o(busy_o), .err_o(err_o), .err_clr_i(err_clr_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_total++;
        if (got === exp) chk_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        tick;
        rx_valid_i = 1'b0;
        tick;
    endtask

    task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] addr, input logic [7:0] len);
        send_byte(cmd);
        for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
        send_byte(len);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_bus(input int n);
        int k = 0;
        while (bus_cnt < n && k < 200) begin tick; k++; end
        tick;
    endtask

    task automatic wait_tx(input int n);
        int k = 0;
        while (tx_cnt < n && k < 200) begin tick; k++; end
        tick;
    endtask

    task automatic wait_req;
        int k = 0;
        while (!req_o && k < 50) begin tick; k++; end
    endtask

    // Bus slave: grant after 3 cycles of req, read data one cycle after grant
    initial begin
        int wait_cnt = 0;
        logic rd_pend = 1'b0;
        gnt_i = 1'b0; valid_i = 1'b0; data_i = 32'h0;
        forever begin
            tick;
            gnt_i   = 1'b0;
            valid_i = 1'b0;
            if (rd_pend) begin
                valid_i = 1'b1;
                data_i  = rd_data[rd_idx];
                rd_idx++;
                rd_pend = 1'b0;
            end
            if (req_o && !gnt_hold) begin
                if (wait_cnt == 3) begin
                    gnt_i = 1'b1;
                    wait_cnt = 0;
                    if (bus_cnt < 16) begin
                        bus_addr_log[bus_cnt] = addr_o;
                        bus_data_log[bus_cnt] = data_o;
                        bus_we_log[bus_cnt]   = we_o;
                    end
                    bus_cnt++;
                    if (!we_o) rd_pend = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Protocol monitor sampled mid-cycle: tx log, strobe spacing, busy, handshake stability
    initial begin
        logic p_req = 1'b0, p_gnt = 1'b0, p_we = 1'b0, p_txv = 1'b0, p_busy = 1'b0, p_en = 1'b0;
        logic [31:0] p_addr = 32'h0, p_data = 32'h0;
        forever begin
            @(negedge clk);
            if (req_o) req_cycles++;
            if (p_req && !p_gnt && p_en && rstn_i && en_i) begin
                if (!req_o || addr_o !== p_addr || we_o !== p_we || data_o !== p_data) hs_viol++;
            end
            if (tx_valid_o && p_txv) consec_viol++;
            if (tx_valid_o && p_busy) busy_viol++;
            if (tx_valid_o) begin
                if (tx_cnt < 32) tx_log[tx_cnt] = tx_data_o;
                tx_cnt++;
            end
            p_req = req_o; p_gnt = gnt_i; p_we = we_o; p_addr = addr_o; p_data = data_o;
            p_txv = tx_valid_o; p_busy = tx_busy_i; p_en = en_i;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_rd;
        logic [31:0] exp_w;
        int rc, bc, tc;
        rstn_i = 1'b0; en_i = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00;
        tx_busy_i = 1'b0; err_clr_i = 1'b0;
        rd_data[0] = 32'hDEADBEEF; rd_data[1] = 32'h01020304;
        rd_data[2] = 32'hCAFEF00D; rd_data[3] = 32'h0;
        #3;
        chk("rst_flags", {req_o, we_o, tx_valid_o, busy_o, err_o}, 64'h0);
        chk("rst_addr", addr_o, 64'h0);
        chk("rst_data", data_o, 64'h0);
        chk("rst_txd", tx_data_o, 64'h0);
        tick; tick;
        rstn_i = 1'b1;
        tick;

        // two-word write
        send_cmd(8'hA5, 32'h0000_1000, 8'h01);
        send_word(32'h44332211);
        wait_bus(1);
        send_word(32'h88776655);
        wait_bus(2);
        wait_tx(1);
        chk("wr_cnt", bus_cnt, 64'd2);
        chk("wr0_addr", {bus_we_log[0], bus_addr_log[0]}, {1'b1, 32'h0000_1000});
        chk("wr0_data", bus_data_log[0], 64'h44332211);
        chk("wr1_addr", {bus_we_log[1], bus_addr_log[1]}, {1'b1, 32'h0000_1004});
        chk("wr1_data", bus_data_log[1], 64'h88776655);
        chk("wr_ack_cnt", tx_cnt, 64'd1);
        chk("wr_ack", tx_log[0], 64'h06);
        chk("wr_idle", {busy_o, err_o}, 64'h0);

        // two-word read with address wrap and tx held busy
        tx_busy_i = 1'b1;
        send_cmd(8'h5A, 32'hFFFF_FFFC, 8'h01);
        wait_bus(3);
        repeat (20) tick;
        chk("rd_hold_tx", tx_cnt, 64'd1);
        chk("rd_hold_busy", busy_o, 64'h1);
        tx_busy_i = 1'b0;
        wait_tx(9);
        repeat (3) tick;
        chk("rd_cnt", bus_cnt, 64'd4);
        chk("rd0_addr", {bus_we_log[2], bus_addr_log[2]}, {1'b0, 32'hFFFF_FFFC});
        chk("rd1_addr", {bus_we_log[3], bus_addr_log[3]}, {1'b0, 32'h0000_0000});
        chk("rd_tx_cnt", tx_cnt, 64'd9);
        exp_rd = 64'h01020304_DEADBEEF;
        for (int i = 0; i < 8; i++) chk("rd_tx", tx_log[1+i], exp_rd[8*i +: 8]);
        chk("rd_idle", {busy_o, err_o}, 64'h0);

        // over-length burst is rejected; exactly MAX_BURST is accepted
        rc = req_cycles; bc = bus_cnt; tc = tx_cnt;
        send_cmd(8'hA5, 32'h0000_0000, 8'h10);
        chk("ovr_err", err_o, 64'h1);
        chk("ovr_idle", busy_o, 64'h0);
        chk("ovr_noreq", req_cycles - rc, 64'd0);
        chk("ovr_nobus", bus_cnt - bc, 64'd0);
        chk("ovr_notx", tx_cnt - tc, 64'd0);
        err_clr_i = 1'b1; tick; err_clr_i = 1'b0;
        chk("ovr_clr", err_o, 64'h0);
        send_cmd(8'hA5, 32'h0000_0000, 8'h0F);
        chk("max_ok", {busy_o, err_o}, 64'h2);
        en_i = 1'b0; tick; en_i = 1'b1;
        chk("max_abort", busy_o, 64'h0);

        // stall after two address bytes until timeout, then a clean read
        send_byte(8'h5A); send_byte(8'h00); send_byte(8'h20);
        repeat (15) tick;
        chk("to_pending", {busy_o, err_o}, 64'h2);
        repeat (10) tick;
        chk("to_fired", {busy_o, err_o}, 64'h1);
        err_clr_i = 1'b1; tick; err_clr_i = 1'b0;
        send_cmd(8'h5A, 32'h0000_2000, 8'h00);
        wait_bus(5);
        wait_tx(13);
        chk("to_rd_addr", {bus_we_log[4], bus_addr_log[4]}, {1'b0, 32'h0000_2000});
        exp_w = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) chk("to_rd_tx", tx_log[9+i], exp_w[8*i +: 8]);
        chk("to_rd_err", err_o, 64'h0);

        // rx while waiting for grant, then disable mid-burst
        gnt_hold = 1'b1;
        send_cmd(8'hA5, 32'h0000_4000, 8'h01);
        send_word(32'h0D0C0B0A);
        wait_req;
        chk("wreq_bus", {req_o, we_o, addr_o, data_o}, {1'b1, 1'b1, 32'h0000_4000, 32'h0D0C0B0A});
        send_byte(8'h99);
        chk("wreq_rx_err", {req_o, busy_o, err_o}, 64'h7);
        en_i = 1'b0; tick;
        chk("en_drop", {req_o, busy_o, err_o}, 64'h1);
        en_i = 1'b1; tick;

        // asynchronous reset while req_o is high
        send_cmd(8'hA5, 32'h0000_3000, 8'h00);
        send_word(32'h55667788);
        wait_req;
        chk("pre_rst_req", {req_o, data_o}, {1'b1, 32'h55667788});
        rstn_i = 1'b0;
        #1;
        chk("async_flags", {req_o, we_o, tx_valid_o, busy_o, err_o}, 64'h0);
        chk("async_bus", {addr_o, data_o}, 64'h0);
        tick; tick;
        rstn_i = 1'b1; gnt_hold = 1'b0;
        tick;
        chk("held_nobus", bus_cnt, 64'd5);

        // fresh single-word write after reset
        send_cmd(8'hA5, 32'h0000_5000, 8'h00);
        send_word(32'h44332211);
        wait_bus(6);
        wait_tx(14);
        chk("post_wr", {bus_we_log[5], bus_addr_log[5], bus_data_log[5]}, {1'b1, 32'h0000_5000, 32'h44332211});
        chk("post_ack", tx_log[13], 64'h06);

        chk("hs_stable", hs_viol, 64'd0);
        chk("tx_spacing", consec_viol, 64'd0);
        chk("tx_busy_respect", busy_viol, 64'd0);

        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end
endmodule
